// File: rtl/imem_portb_arbiter.sv
// Round-robin arbiter sharing imem port B between M0 (debug/host loader)
// and M1 (DMA engine), with a bounded burst lock and 1-cycle read return.
module imem_portb_arbiter #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_LOCK   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    m0_req,
    input  logic                    m0_lock,
    input  logic                    m0_we,
    input  logic [DATA_WIDTH/8-1:0] m0_wstrb,
    input  logic [ADDR_WIDTH-1:0]   m0_addr,
    input  logic [DATA_WIDTH-1:0]   m0_wdata,
    output logic                    m0_gnt,
    output logic                    m0_rvalid,
    output logic [DATA_WIDTH-1:0]   m0_rdata,
    input  logic                    m1_req,
    input  logic                    m1_lock,
    input  logic                    m1_we,
    input  logic [DATA_WIDTH/8-1:0] m1_wstrb,
    input  logic [ADDR_WIDTH-1:0]   m1_addr,
    input  logic [DATA_WIDTH-1:0]   m1_wdata,
    output logic                    m1_gnt,
    output logic                    m1_rvalid,
    output logic [DATA_WIDTH-1:0]   m1_rdata,
    output logic                    en_b,
    output logic                    we_b,
    output logic [DATA_WIDTH/8-1:0] wstrb_b,
    output logic [ADDR_WIDTH-1:0]   addr_b,
    output logic [DATA_WIDTH-1:0]   din_b,
    input  logic [DATA_WIDTH-1:0]   dout_b
);

    localparam logic [7:0] LOCK_LIMIT = 8'(MAX_LOCK);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic       last_served;       // 0 = M0, 1 = M1
    logic       last_served_next;
    logic [7:0] lock_cnt;
    logic [7:0] lock_cnt_next;
    logic       rd_pend;
    logic       rd_owner;          // 0 = M0, 1 = M1
    logic       gnt0;
    logic       gnt1;
    logic       keep0;
    logic       keep1;
    logic       at_limit;

    // State register, burst counter, round-robin pointer and read tracking
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_served <= 1'b1;
            lock_cnt    <= '0;
            rd_pend     <= 1'b0;
            rd_owner    <= 1'b0;
        end else begin
            state       <= state_next;
            last_served <= last_served_next;
            lock_cnt    <= lock_cnt_next;
            rd_pend     <= (gnt0 & ~m0_we) | (gnt1 & ~m1_we);
            rd_owner    <= gnt1;
        end
    end

    // Arbitration and next-state: a lock owner keeps priority unless it
    // stops requesting or has hit the lock limit while the other waits; in
    // either case the cycle falls back to plain round-robin, where
    // last_served already points at the owner so the other side wins.
    always_comb begin
        gnt0             = 1'b0;
        gnt1             = 1'b0;
        keep0            = 1'b0;
        keep1            = 1'b0;
        state_next       = IDLE;
        lock_cnt_next    = '0;
        last_served_next = last_served;
        at_limit         = (lock_cnt >= LOCK_LIMIT);

        case (state)
            LOCK0:   keep0 = m0_req && !(at_limit && m1_req);
            LOCK1:   keep1 = m1_req && !(at_limit && m0_req);
            default: ;
        endcase

        if (!rst_n) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end else if (keep0) begin
            gnt0 = 1'b1;
        end else if (keep1) begin
            gnt1 = 1'b1;
        end else if (m0_req && m1_req) begin
            gnt0 = last_served;
            gnt1 = ~last_served;
        end else begin
            gnt0 = m0_req;
            gnt1 = m1_req;
        end

        if (gnt0) begin
            last_served_next = 1'b0;
            if (m0_lock) begin
                state_next    = LOCK0;
                lock_cnt_next = keep0 ? (at_limit ? lock_cnt : lock_cnt + 8'd1) : 8'd1;
            end
        end else if (gnt1) begin
            last_served_next = 1'b1;
            if (m1_lock) begin
                state_next    = LOCK1;
                lock_cnt_next = keep1 ? (at_limit ? lock_cnt : lock_cnt + 8'd1) : 8'd1;
            end
        end
    end

    // Outputs: grants, port B drive from the winner, read data routing
    always_comb begin
        m0_gnt    = gnt0;
        m1_gnt    = gnt1;
        en_b      = gnt0 | gnt1;
        we_b      = 1'b0;
        wstrb_b   = '0;
        addr_b    = '0;
        din_b     = '0;
        if (gnt0) begin
            we_b    = m0_we;
            wstrb_b = m0_we ? m0_wstrb : '0;
            addr_b  = m0_addr;
            din_b   = m0_wdata;
        end else if (gnt1) begin
            we_b    = m1_we;
            wstrb_b = m1_we ? m1_wstrb : '0;
            addr_b  = m1_addr;
            din_b   = m1_wdata;
        end
        m0_rvalid = rst_n & rd_pend & ~rd_owner;
        m1_rvalid = rst_n & rd_pend & rd_owner;
        m0_rdata  = m0_rvalid ? dout_b : '0;
        m1_rdata  = m1_rvalid ? dout_b : '0;
    end

endmodule

// File: tb/tb_imem_portb_arbiter.sv
// Bench for imem_portb_arbiter: an imem port B model, a transaction-level
// reference model compared on every cycle, and directed scenarios with
// hand-computed expectations.
module tb_imem_portb_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int ML = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          m0_req, m0_lock, m0_we, m1_req, m1_lock, m1_we;
    logic [SW-1:0] m0_wstrb, m1_wstrb;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          en_b, we_b;
    logic [SW-1:0] wstrb_b;
    logic [AW-1:0] addr_b;
    logic [DW-1:0] din_b;
    logic [DW-1:0] dout_b;
    logic          preload;

    int checks = 0;
    int errors = 0;

    imem_portb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_LOCK(ML)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_we(m0_we), .m0_wstrb(m0_wstrb),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_gnt(m0_gnt),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_we(m1_we), .m1_wstrb(m1_wstrb),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_gnt(m1_gnt),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .en_b(en_b), .we_b(we_b), .wstrb_b(wstrb_b), .addr_b(addr_b),
        .din_b(din_b), .dout_b(dout_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // imem port B: 1-cycle read latency, byte-strobed writes
    logic [DW-1:0] mem [1024];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 1024; i++) mem[i] <= '0;
            mem[10'h010] <= 32'hDEADBEEF;
            mem[10'h020] <= 32'h12345678;
            mem[10'h005] <= 32'hFFFFFFFF;
        end else if (en_b) begin
            if (we_b)
                for (int b = 0; b < SW; b++)
                    if (wstrb_b[b]) mem[addr_b][8*b +: 8] <= din_b[8*b +: 8];
            dout_b <= mem[addr_b];
        end
    end

    // Reference model: owner/beat-count/last-winner view of the arbiter,
    // evaluated on the falling edge, then advanced as if across the next rising edge
    logic [DW-1:0] ref_mem [1024];
    bit            ref_init = 0;
    int            m_owner = -1, m_cnt = 0, m_last = 1, m_pend_owner = 0;
    bit            m_pend = 0;
    logic [DW-1:0] m_pend_data = '0;

    always @(negedge clk) begin : model
        int            w;
        logic          r[2], lk[2], we[2];
        logic [SW-1:0] st[2];
        logic [AW-1:0] ad[2];
        logic [DW-1:0] wd[2];
        logic          e_rv0, e_rv1;
        if (!ref_init) begin
            for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
            ref_mem[10'h010] = 32'hDEADBEEF;
            ref_mem[10'h020] = 32'h12345678;
            ref_mem[10'h005] = 32'hFFFFFFFF;
            ref_init = 1;
        end
        r[0] = m0_req;  r[1] = m1_req;  lk[0] = m0_lock;  lk[1] = m1_lock;
        we[0] = m0_we;  we[1] = m1_we;  st[0] = m0_wstrb; st[1] = m1_wstrb;
        ad[0] = m0_addr; ad[1] = m1_addr; wd[0] = m0_wdata; wd[1] = m1_wdata;

        if (rst_n !== 1'b1) w = -1;
        else if (m_owner >= 0 && r[m_owner] && !(m_cnt >= ML && r[1 - m_owner])) w = m_owner;
        else if (r[0] && r[1]) w = 1 - m_last;
        else if (r[0]) w = 0;
        else if (r[1]) w = 1;
        else w = -1;

        chk("m0_gnt", m0_gnt, w == 0);
        chk("m1_gnt", m1_gnt, w == 1);
        chk("en_b", en_b, w >= 0);
        chk("we_b", we_b, (w >= 0) ? we[w] : 1'b0);
        chk("wstrb_b", wstrb_b, (w >= 0 && we[w]) ? st[w] : '0);
        chk("addr_b", addr_b, (w >= 0) ? ad[w] : '0);
        chk("din_b", din_b, (w >= 0) ? wd[w] : '0);
        e_rv0 = (rst_n === 1'b1) && m_pend && m_pend_owner == 0;
        e_rv1 = (rst_n === 1'b1) && m_pend && m_pend_owner == 1;
        chk("m0_rvalid", m0_rvalid, e_rv0);
        chk("m1_rvalid", m1_rvalid, e_rv1);
        chk("m0_rdata", m0_rdata, e_rv0 ? m_pend_data : '0);
        chk("m1_rdata", m1_rdata, e_rv1 ? m_pend_data : '0);

        if (rst_n !== 1'b1) begin
            m_owner = -1; m_cnt = 0; m_last = 1; m_pend = 0;
        end else begin
            m_pend = (w >= 0) && !we[w];
            if (m_pend) begin
                m_pend_owner = w;
                m_pend_data  = ref_mem[ad[w]];
            end
            if (w >= 0 && we[w])
                for (int b = 0; b < SW; b++)
                    if (st[w][b]) ref_mem[ad[w]][8*b +: 8] = wd[w][8*b +: 8];
            if (w >= 0) begin
                m_last = w;
                if (lk[w]) begin
                    if (m_owner == w) m_cnt = (m_cnt < ML) ? m_cnt + 1 : ML;
                    else begin m_owner = w; m_cnt = 1; end
                end else begin
                    m_owner = -1; m_cnt = 0;
                end
            end else begin
                m_owner = -1; m_cnt = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        m0_req = 0; m0_lock = 0; m0_we = 0; m0_wstrb = '0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_lock = 0; m1_we = 0; m1_wstrb = '0; m1_addr = '0; m1_wdata = '0;
    endtask

    initial begin : stim
        int m1b, m0_at, waited;
        bit m0_done, got;
        preload = 1;
        rst_n   = 0;
        idle_all();
        // Reset held with both requesting
        m0_req = 1; m0_addr = 10'h010;
        m1_req = 1; m1_addr = 10'h020;
        step();
        preload = 0;
        @(negedge clk);
        chk("rst_m0_gnt", m0_gnt, 0);
        chk("rst_en_b", en_b, 0);
        step();
        step();

        // Round-robin of unlocked reads
        rst_n = 1;
        @(negedge clk);
        chk("first_m0_gnt", m0_gnt, 1);
        chk("first_m1_gnt", m1_gnt, 0);
        chk("first_en_b", en_b, 1);
        chk("first_addr_b", addr_b, 10'h010);
        for (int i = 1; i < 8; i++) begin
            step();
            @(negedge clk);
            chk("rr_m0_gnt", m0_gnt, (i % 2) == 0);
            if (i % 2 == 1) begin
                chk("rr_m0_rvalid", m0_rvalid, 1);
                chk("rr_m0_rdata", m0_rdata, 32'hDEADBEEF);
                chk("rr_m1_rvalid", m1_rvalid, 0);
            end else begin
                chk("rr_m1_rvalid", m1_rvalid, 1);
                chk("rr_m1_rdata", m1_rdata, 32'h12345678);
                chk("rr_m0_rvalid", m0_rvalid, 0);
            end
        end
        step();
        idle_all();

        // M1 locked write burst of 20 beats, M0 joining from beat 3
        m1b = 0; m0_at = -1; m0_done = 0;
        for (int cyc = 0; cyc < 40 && m1b < 20; cyc++) begin
            step();
            m1_req = 1; m1_lock = 1; m1_we = 1; m1_wstrb = '1;
            m1_addr = AW'(10'h100 + m1b); m1_wdata = DW'(m1b);
            m0_req = (m1b >= 2) && !m0_done;
            m0_we = 1; m0_wstrb = '1; m0_addr = 10'h200; m0_wdata = 32'h55;
            @(negedge clk);
            if (m0_gnt) begin m0_at = m1b; m0_done = 1; end
            if (m1_gnt) m1b++;
        end
        chk("burst_m1_beats", m1b, 20);
        chk("burst_m0_after", m0_at, 16);
        step();
        idle_all();

        // Partial-strobe write then read-back
        step();
        m0_req = 1; m0_we = 1; m0_wstrb = 4'b0011; m0_addr = 10'h005; m0_wdata = 32'hA5A5A5A5;
        @(negedge clk);
        chk("wr_gnt", m0_gnt, 1);
        chk("wr_wstrb_b", wstrb_b, 4'b0011);
        step();
        m0_we = 0;
        @(negedge clk);
        chk("rd_gnt", m0_gnt, 1);
        step();
        m0_req = 0;
        @(negedge clk);
        chk("rd_rvalid", m0_rvalid, 1);
        chk("rd_rdata", m0_rdata, 32'hFFFFA5A5);

        // Lock owner drops req: the other side takes over in the same cycle
        step();
        m0_req = 1; m0_lock = 1; m0_we = 0; m0_wstrb = '0; m0_addr = 10'h010;
        @(negedge clk);
        chk("lk_m0_gnt", m0_gnt, 1);
        step();
        m1_req = 1; m1_lock = 1; m1_we = 0; m1_addr = 10'h020;
        @(negedge clk);
        chk("lk_hold_m0", m0_gnt, 1);
        chk("lk_hold_m1", m1_gnt, 0);
        step();
        m0_req = 0;
        @(negedge clk);
        chk("lk_drop_m1", m1_gnt, 1);
        step();
        m0_req = 1; m0_lock = 0;
        @(negedge clk);
        chk("lk_new_owner_m1", m1_gnt, 1);
        chk("lk_new_owner_m0", m0_gnt, 0);
        step();
        m1_lock = 0;
        @(negedge clk);
        chk("lk_last_m1", m1_gnt, 1);
        step();
        m1_req = 0;
        @(negedge clk);
        chk("lk_after_m0", m0_gnt, 1);
        step();
        idle_all();

        // Reset right after an accepted M1 read
        m1_req = 1; m1_addr = 10'h020;
        @(negedge clk);
        chk("rr_rst_m1_gnt", m1_gnt, 1);
        step();
        rst_n = 0; m1_req = 0;
        @(negedge clk);
        chk("rst_m1_rvalid", m1_rvalid, 0);
        chk("rst_m1_rdata", m1_rdata, 0);
        step();
        m0_req = 1; m1_req = 1; m0_addr = 10'h010;
        @(negedge clk);
        chk("rst_hold_m0_gnt", m0_gnt, 0);
        step();
        rst_n = 1;
        got = 0; waited = 0;
        while (!got && waited < 4) begin
            @(negedge clk);
            if (m0_gnt || m1_gnt) got = 1;
            else begin waited++; step(); end
        end
        chk("post_rst_granted", got, 1);
        chk("post_rst_m0_first", m0_gnt, 1);
        chk("post_rst_latency", waited, 0);
        step();
        idle_all();
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
